program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams a length-prefixed program from a byte interface into instruction memory,
// holding the CPU until the whole image has been written.
module program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'd10,
    parameter int          MAX_WORDS = 64
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        ImemWrite,
    output logic [15:0] ImemAddr,
    output logic [15:0] ImemData,
    output logic        CpuRun,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [7:0]  len_hi;
    logic [7:0]  data_hi;
    logic [15:0] len;
    logic [15:0] count;
    logic [15:0] addr;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] length_word;
    logic [15:0] count_inc;
    logic        xfer;

    assign length_word = {len_hi, ByteIn};
    assign count_inc   = count + 16'd1;
    assign xfer        = ByteValid && ByteReady;
    assign ImemAddr    = imem_addr;
    assign ImemData    = imem_data;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ByteReady  = 1'b0;
        Busy       = 1'b0;
        ImemWrite  = 1'b0;
        Done       = 1'b0;
        CpuRun     = 1'b0;
        Error      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_next = LEN_HI;
            end
            DONE: begin
                Done   = 1'b1;
                CpuRun = 1'b1;
                if (Start) state_next = LEN_HI;
            end
            ERROR: begin
                Error = 1'b1;
                if (Start) state_next = LEN_HI;
            end
            LEN_HI: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid) state_next = LEN_LO;
            end
            LEN_LO: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid) begin
                    if (length_word == 16'd0) begin
                        state_next = DONE;
                    end else if ({1'b0, length_word} > MAX_LEN) begin
                        state_next = ERROR;
                    end else begin
                        state_next = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid) state_next = DATA_LO;
            end
            DATA_LO: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid) state_next = WRITE;
            end
            WRITE: begin
                Busy       = 1'b1;
                ImemWrite  = 1'b1;
                state_next = (count_inc == len) ? DONE : DATA_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // The memory-side address/data are captured on the low-byte edge so they are
    // stable through WRITE and keep their last value afterwards.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            len_hi    <= 8'd0;
            data_hi   <= 8'd0;
            len       <= 16'd0;
            count     <= 16'd0;
            addr      <= BASE_ADDR;
            imem_addr <= BASE_ADDR;
            imem_data <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (Start) begin
                        count <= 16'd0;
                        addr  <= BASE_ADDR;
                    end
                end
                LEN_HI: begin
                    if (xfer) len_hi <= ByteIn;
                end
                LEN_LO: begin
                    if (xfer) len <= length_word;
                end
                DATA_HI: begin
                    if (xfer) data_hi <= ByteIn;
                end
                DATA_LO: begin
                    if (xfer) begin
                        imem_addr <= addr;
                        imem_data <= {data_hi, ByteIn};
                    end
                end
                WRITE: begin
                    count <= count_inc;
                    addr  <= addr + 16'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus random programs
// compared against a stream-level model of expected memory writes and final status.
module tb_program_loader;

    localparam logic [15:0] BASE = 16'd10;
    localparam int          MAXW = 64;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  ByteIn = 8'd0;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic        ImemWrite;
    logic [15:0] ImemAddr;
    logic [15:0] ImemData;
    logic        CpuRun;
    logic        Busy;
    logic        Done;
    logic        Error;

    int total = 0;
    int bad = 0;

    logic [31:0] obs_q[$];
    logic [15:0] prog_q[$];

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .Clock(Clock),
        .ResetN(ResetN),
        .Start(Start),
        .ByteIn(ByteIn),
        .ByteValid(ByteValid),
        .ByteReady(ByteReady),
        .ImemWrite(ImemWrite),
        .ImemAddr(ImemAddr),
        .ImemData(ImemData),
        .CpuRun(CpuRun),
        .Busy(Busy),
        .Done(Done),
        .Error(Error)
    );

    always #5 Clock = ~Clock;

    // Every cycle with the write strobe up is logged as {addr, data}.
    always @(negedge Clock) begin
        if (ImemWrite === 1'b1) obs_q.push_back({ImemAddr, ImemData});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic do_reset();
        Start     = 1'b0;
        ByteValid = 1'b0;
        ResetN    = 1'b0;
        tick(2);
        ResetN = 1'b1;
        tick(1);
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    // Entered at a negedge; returns at the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        ByteIn    = b;
        ByteValid = 1'b1;
        while (ByteReady !== 1'b1 && t < 50) begin
            @(negedge Clock);
            t++;
        end
        if (t >= 50) check("byte_ready_timeout", 32'(ByteReady), 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        ByteValid = 1'b0;
        ByteIn    = 8'($urandom);
        tick(gap);
    endtask

    // Streams length + prog_q[0..len-1] and checks the model's writes and status.
    task automatic run_load(input logic [15:0] len, input int gap, input int long_at);
        logic [7:0]  bytes[$];
        logic [31:0] exp_q[$];
        logic [15:0] w;
        bit          accepted;
        int          g;
        accepted = (int'(len) <= MAXW);
        bytes.push_back(len[15:8]);
        bytes.push_back(len[7:0]);
        if (accepted) begin
            for (int i = 0; i < int'(len); i++) begin
                w = prog_q[i];
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
                exp_q.push_back({16'(BASE + 16'(2 * i)), w});
            end
        end
        obs_q.delete();
        start_pulse();
        check("busy_at_start", 32'(Busy), 32'd1);
        check("cpurun_at_start", 32'(CpuRun), 32'd0);
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == bytes.size() - 1) g = 0;
            else if (i == long_at) g = 10;
            else if (gap < 0) g = $urandom_range(0, 3);
            else g = gap;
            send_byte(bytes[i], g);
            if (i == long_at) check("busy_in_gap", 32'(Busy), 32'd1);
        end
        if (exp_q.size() > 0) check("write_after_last_byte", 32'(ImemWrite), 32'd1);
        tick(1);
        check("write_one_cycle", 32'(ImemWrite), 32'd0);
        tick(1);
        check("done", 32'(Done), 32'(accepted));
        check("error", 32'(Error), 32'(!accepted));
        check("cpurun", 32'(CpuRun), 32'(accepted));
        check("busy_end", 32'(Busy), 32'd0);
        check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("write_addr_data", obs_q[i], exp_q[i]);
        if (exp_q.size() > 0) check("addr_hold", 32'(ImemAddr), 32'(exp_q[exp_q.size() - 1][31:16]));
    endtask

    initial begin
        int kind;
        logic [15:0] rl;

        do_reset();
        check("rst_byteready", 32'(ByteReady), 32'd0);
        check("rst_imemwrite", 32'(ImemWrite), 32'd0);
        check("rst_cpurun", 32'(CpuRun), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_addr", 32'(ImemAddr), 32'(BASE));
        check("rst_data", 32'(ImemData), 32'd0);

        $display("[TB] two-word program");
        prog_q = {16'h1234, 16'hABCD};
        run_load(16'd2, 0, -1);

        $display("[TB] empty program");
        run_load(16'd0, 0, -1);

        $display("[TB] oversize then single word");
        run_load(16'd65, 0, -1);
        prog_q = {16'hFF00};
        run_load(16'd1, 0, -1);

        $display("[TB] toggling valid with long gap");
        prog_q = {16'h0F1E, 16'h2D3C, 16'h4B5A};
        run_load(16'd3, 1, 4);

        $display("[TB] reset during write");
        obs_q.delete();
        start_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 2);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        check("rw_in_write", 32'(ImemWrite), 32'd1);
        #1 ResetN = 1'b0;
        #1;
        check("rw_write_drop", 32'(ImemWrite), 32'd0);
        check("rw_busy", 32'(Busy), 32'd0);
        check("rw_addr", 32'(ImemAddr), 32'(BASE));
        check("rw_data", 32'(ImemData), 32'd0);
        check("rw_cpurun", 32'(CpuRun), 32'd0);
        tick(2);
        ResetN    = 1'b1;
        ByteValid = 1'b1;
        ByteIn    = 8'h00;
        tick(5);
        check("rw_idle_ready", 32'(ByteReady), 32'd0);
        check("rw_idle_busy", 32'(Busy), 32'd0);
        ByteValid = 1'b0;
        prog_q = {16'hC0DE};
        run_load(16'd1, 0, -1);

        $display("[TB] start held during load");
        obs_q.delete();
        Start = 1'b1;
        tick(1);
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 1);
        send_byte(8'hBE, 1);
        send_byte(8'hEF, 0);
        tick(1);
        check("sh_cpurun_done", 32'(CpuRun), 32'd1);
        check("sh_writes", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            check("sh_w0", obs_q[0], {BASE, 16'hDEAD});
            check("sh_w1", obs_q[1], {16'(BASE + 16'd2), 16'hBEEF});
        end
        tick(1);
        check("sh_restart_cpurun", 32'(CpuRun), 32'd0);
        check("sh_restart_busy", 32'(Busy), 32'd1);
        Start = 1'b0;
        do_reset();

        $display("[TB] random programs");
        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) rl = 16'd0;
            else if (kind == 1) rl = 16'(MAXW + 1 + $urandom_range(0, 1000));
            else if (kind == 2) rl = 16'(MAXW);
            else rl = 16'($urandom_range(1, 8));
            prog_q.delete();
            for (int i = 0; i < MAXW; i++) prog_q.push_back(16'($urandom));
            run_load(rl, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
